// File: rtl/encoder.vh
// Encoder word geometry shared by the encoder datapath blocks.
`ifndef ENCODER_VH
`define ENCODER_VH
`define ENC_SYM_NUM 4
`define EGF_ORDER   8
`endif

// File: rtl/enc_ingress.sv
// Ingress FIFO in front of the encoder: buffers source words and presents the
// head word to the downstream buffer, flagging consumes from an empty FIFO.
`include "encoder.vh"

module enc_ingress #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [`ENC_SYM_NUM-1:0][`EGF_ORDER-1:0] in_data,
    input  logic                                   buf_enable,
    output logic [`ENC_SYM_NUM-1:0][`EGF_ORDER-1:0] enc_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]         enc_level,
    output logic                                   enc_underflow,
    input  logic                                   enc_clear
);

    localparam int SYM_NUM = `ENC_SYM_NUM;
    localparam int ORDER   = `EGF_ORDER;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = $clog2(FIFO_DEPTH + 1);

    typedef logic [SYM_NUM-1:0][ORDER-1:0] word_t;

    word_t              mem_q [FIFO_DEPTH];
    word_t              mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               underflow_q, underflow_d;
    logic               push;
    logic               pop;
    logic               empty;

    // in_ready depends only on the level register, so a pop never frees a slot
    // for a push in the same cycle.
    assign empty    = (level_q == '0);
    assign in_ready = (level_q < LVL_W'(FIFO_DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = buf_enable && !empty;

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        underflow_d = underflow_q;

        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        // A new underflow takes priority over a clear in the same cycle.
        if (buf_enable && empty) begin
            underflow_d = 1'b1;
        end else if (enc_clear) begin
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage needs no reset: the level gates every read of it.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign enc_data      = empty ? word_t'('0) : mem_q[rd_ptr_q];
    assign enc_level     = level_q;
    assign enc_underflow = underflow_q;

endmodule

// File: tb/tb_enc_ingress.sv
// Directed testbench for enc_ingress with hand-computed expectations.
`timescale 1ns/1ps

module tb_enc_ingress;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         buf_enable;
    logic [W-1:0] enc_data;
    logic [2:0]   enc_level;
    logic         enc_underflow;
    logic         enc_clear;

    int checks;
    int failures;

    enc_ingress #(.FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .buf_enable    (buf_enable),
        .enc_data      (enc_data),
        .enc_level     (enc_level),
        .enc_underflow (enc_underflow),
        .enc_clear     (enc_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs are changed and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        buf_enable = 1'b0;
        enc_clear  = 1'b0;
        in_data    = '0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #12;
        checks++;
        if (enc_level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", enc_level); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++;
        if (enc_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", enc_data); end
        checks++;
        if (enc_underflow !== 1'b0) begin failures++; $display("FAIL reset_underflow got=%b exp=0", enc_underflow); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i);
            #1;
            if (i == 1) begin
                checks++;
                if (enc_data !== 32'h0) begin failures++; $display("FAIL fill_no_fallthrough got=%h exp=0", enc_data); end
            end
            tick();
            checks++;
            if (enc_level !== 3'(i)) begin failures++; $display("FAIL fill_level got=%0d exp=%0d", enc_level, i); end
        end
        idle();
        #1;
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
        checks++;
        if (enc_data !== 32'h1) begin failures++; $display("FAIL fill_head got=%h exp=1", enc_data); end
    endtask

    task automatic test_drain();
        buf_enable = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            checks++;
            if (enc_data !== 32'(i)) begin failures++; $display("FAIL drain_data got=%h exp=%h", enc_data, 32'(i)); end
            tick();
        end
        idle();
        #1;
        checks++;
        if (enc_level !== 3'd0) begin failures++; $display("FAIL drain_level got=%0d exp=0", enc_level); end
        checks++;
        if (enc_data !== 32'h0) begin failures++; $display("FAIL drain_empty_data got=%h exp=0", enc_data); end
        checks++;
        if (enc_underflow !== 1'b0) begin failures++; $display("FAIL drain_no_underflow got=%b exp=0", enc_underflow); end
    endtask

    task automatic test_streaming();
        logic [W-1:0] words [14];
        for (int i = 0; i < 14; i++) words[i] = {8'hA0 + 8'(i), 8'hB1, 8'hC2 + 8'(i), 8'(i)};
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = words[i];
            tick();
        end
        buf_enable = 1'b1;
        for (int i = 2; i < 14; i++) begin
            in_data = words[i];
            #1;
            checks++;
            if (enc_data !== words[i-2]) begin failures++; $display("FAIL stream_data got=%h exp=%h", enc_data, words[i-2]); end
            tick();
            checks++;
            if (enc_level !== 3'd2) begin failures++; $display("FAIL stream_level got=%0d exp=2", enc_level); end
        end
        in_valid = 1'b0;
        for (int i = 12; i < 14; i++) begin
            #1;
            checks++;
            if (enc_data !== words[i]) begin failures++; $display("FAIL stream_tail got=%h exp=%h", enc_data, words[i]); end
            tick();
        end
        idle();
        #1;
        checks++;
        if (enc_level !== 3'd0) begin failures++; $display("FAIL stream_end_level got=%0d exp=0", enc_level); end
    endtask

    task automatic test_underflow();
        buf_enable = 1'b1;
        tick();
        checks++;
        if (enc_underflow !== 1'b1) begin failures++; $display("FAIL uf_set got=%b exp=1", enc_underflow); end
        checks++;
        if (enc_level !== 3'd0) begin failures++; $display("FAIL uf_level got=%0d exp=0", enc_level); end
        checks++;
        if (enc_data !== 32'h0) begin failures++; $display("FAIL uf_data got=%h exp=0", enc_data); end
        enc_clear = 1'b1;
        tick();
        checks++;
        if (enc_underflow !== 1'b1) begin failures++; $display("FAIL uf_set_wins got=%b exp=1", enc_underflow); end
        buf_enable = 1'b0;
        tick();
        checks++;
        if (enc_underflow !== 1'b0) begin failures++; $display("FAIL uf_clear got=%b exp=0", enc_underflow); end
        idle();
        tick();
        checks++;
        if (enc_underflow !== 1'b0) begin failures++; $display("FAIL uf_stays_clear got=%b exp=0", enc_underflow); end
    endtask

    task automatic test_full_pop();
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 32'h11 + 32'(i);
            tick();
        end
        in_data    = 32'h15;
        buf_enable = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
        tick();
        checks++;
        if (enc_level !== 3'd3) begin failures++; $display("FAIL full_pop_level got=%0d exp=3", enc_level); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL full_freed_ready got=%b exp=1", in_ready); end
        checks++;
        if (enc_data !== 32'h12) begin failures++; $display("FAIL full_pop_head got=%h exp=12", enc_data); end
        tick();
        checks++;
        if (enc_level !== 3'd3) begin failures++; $display("FAIL full_push_level got=%0d exp=3", enc_level); end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (enc_data !== 32'h13 + 32'(i)) begin failures++; $display("FAIL full_order got=%h exp=%h", enc_data, 32'h13 + 32'(i)); end
            tick();
        end
        idle();
        #1;
        checks++;
        if (enc_level !== 3'd0) begin failures++; $display("FAIL full_end_level got=%0d exp=0", enc_level); end
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'h21 + 32'(i);
            tick();
        end
        idle();
        #1;
        checks++;
        if (enc_level !== 3'd3) begin failures++; $display("FAIL ar_pre_level got=%0d exp=3", enc_level); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (enc_level !== 3'd0) begin failures++; $display("FAIL ar_level got=%0d exp=0", enc_level); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL ar_in_ready got=%b exp=1", in_ready); end
        checks++;
        if (enc_data !== 32'h0) begin failures++; $display("FAIL ar_data got=%h exp=0", enc_data); end
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        tick();
        idle();
        #1;
        checks++;
        if (enc_level !== 3'd1) begin failures++; $display("FAIL ar_new_level got=%0d exp=1", enc_level); end
        checks++;
        if (enc_data !== 32'hDEADBEEF) begin failures++; $display("FAIL ar_new_head got=%h exp=deadbeef", enc_data); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;
        idle();
        test_reset();
        test_fill();
        test_drain();
        test_streaming();
        test_underflow();
        test_full_pop();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
